acc_mem_arbiter: RTL and testbench

- Shares the single accelerator-side data-memory port among NUM_ACC accelerator control units.
- Arbitration is round-robin; each control unit issues read requests (one MEM_READ_DATA_SIZE line) and write requests (one MEM_WRITE_DATA_SIZE word).
- Sits between the accelerator control units and the data memory's accelerator port, and generates each unit's read_data_valid and write_done pulses.
- One transaction is in flight at a time. Address and data are captured at grant.

---
 rtl/acc_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_acc_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among accelerator units.
// One transaction in flight; address/data captured at grant.
module acc_mem_arbiter #(
    parameter int NUM_ACC             = 4,
    parameter int MEM_ADDR_SIZE       = 16,
    parameter int MEM_READ_DATA_SIZE  = 512,
    parameter int MEM_WRITE_DATA_SIZE = 32,
    parameter int MEM_RD_LATENCY      = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_ACC-1:0]                     acc_read_en,
    input  logic [NUM_ACC*MEM_ADDR_SIZE-1:0]       acc_read_addr,
    input  logic [NUM_ACC-1:0]                     acc_write_en,
    input  logic [NUM_ACC*MEM_ADDR_SIZE-1:0]       acc_write_addr,
    input  logic [NUM_ACC*MEM_WRITE_DATA_SIZE-1:0] acc_write_data,
    output logic [MEM_READ_DATA_SIZE-1:0]          acc_read_data,
    output logic [NUM_ACC-1:0]                     acc_read_data_valid,
    output logic [NUM_ACC-1:0]                     acc_write_done,
    output logic [MEM_ADDR_SIZE-1:0]               mem_addr,
    output logic                                   mem_rd_en,
    output logic                                   mem_wr_en,
    output logic [MEM_WRITE_DATA_SIZE-1:0]         mem_wr_data,
    input  logic [MEM_READ_DATA_SIZE-1:0]          mem_rd_data,
    output logic                                   busy
);

    localparam int IW = $clog2(NUM_ACC);
    localparam int CW = $clog2(MEM_RD_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE_RD, RD_WAIT, RESP_RD, ISSUE_WR, RESP_WR
    } state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      idx;
    logic               found;
    logic [CW-1:0]      cnt;
    logic [NUM_ACC-1:0] pending;

    // First pending requester after the pointer, wrapping around
    always_comb begin
        pending = acc_read_en | acc_write_en;
        found   = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int k = 1; k <= NUM_ACC; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_ACC);
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            ptr                 <= IW'(NUM_ACC - 1);
            win_idx             <= '0;
            cnt                 <= '0;
            acc_read_data       <= '0;
            acc_read_data_valid <= '0;
            acc_write_done      <= '0;
            mem_addr            <= '0;
            mem_rd_en           <= 1'b0;
            mem_wr_en           <= 1'b0;
            mem_wr_data         <= '0;
            busy                <= 1'b0;
        end else begin
            acc_read_data_valid <= '0;
            acc_write_done      <= '0;
            mem_addr            <= '0;
            mem_rd_en           <= 1'b0;
            mem_wr_en           <= 1'b0;
            mem_wr_data         <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        win_idx <= pick;
                        ptr     <= pick;
                        busy    <= 1'b1;
                        if (acc_read_en[pick]) begin
                            state     <= ISSUE_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <=
                                acc_read_addr[pick*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
                        end else begin
                            state       <= ISSUE_WR;
                            mem_wr_en   <= 1'b1;
                            mem_addr    <=
                                acc_write_addr[pick*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
                            mem_wr_data <= acc_write_data[
                                pick*MEM_WRITE_DATA_SIZE +: MEM_WRITE_DATA_SIZE];
                        end
                    end
                end
                ISSUE_RD: begin
                    state <= RD_WAIT;
                    cnt   <= CW'(MEM_RD_LATENCY - 1);
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        state               <= RESP_RD;
                        acc_read_data       <= mem_rd_data;
                        acc_read_data_valid <= NUM_ACC'(1) << win_idx;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ISSUE_WR: begin
                    state          <= RESP_WR;
                    acc_write_done <= NUM_ACC'(1) << win_idx;
                end
                RESP_RD, RESP_WR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed bench for acc_mem_arbiter: latency-1 and latency-3 instances
// sharing requester stimulus, each with its own memory model.
module tb_acc_mem_arbiter;

    localparam logic [511:0] JUNK = {16{32'hDEADBEEF}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   rd_en, wr_en;
    logic [63:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;

    logic [511:0] rdata, mrdata, rdata3, mrdata3;
    logic [3:0]   rvalid, wdone, rvalid3, wdone3;
    logic [15:0]  maddr, maddr3;
    logic         mrd, mwr, busy, mrd3, mwr3, busy3;
    logic [31:0]  mwdata, mwdata3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input logic [15:0] a);
        return {16{a, ~a}};
    endfunction

    logic        m1_v;
    logic [15:0] m1_a;
    logic [2:0]  m3_v;
    logic [15:0] m3_a [3];

    always @(posedge clk) begin
        m1_v    <= mrd;
        m1_a    <= maddr;
        m3_v    <= {m3_v[1:0], mrd3};
        m3_a[0] <= maddr3;
        m3_a[1] <= m3_a[0];
        m3_a[2] <= m3_a[1];
    end

    assign mrdata  = m1_v ? pat(m1_a) : JUNK;
    assign mrdata3 = m3_v[2] ? pat(m3_a[2]) : JUNK;

    acc_mem_arbiter #(.MEM_RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .acc_read_en(rd_en), .acc_read_addr(rd_addr),
        .acc_write_en(wr_en), .acc_write_addr(wr_addr),
        .acc_write_data(wr_data),
        .acc_read_data(rdata), .acc_read_data_valid(rvalid),
        .acc_write_done(wdone), .mem_addr(maddr),
        .mem_rd_en(mrd), .mem_wr_en(mwr), .mem_wr_data(mwdata),
        .mem_rd_data(mrdata), .busy(busy)
    );

    acc_mem_arbiter #(.MEM_RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .acc_read_en(rd_en), .acc_read_addr(rd_addr),
        .acc_write_en(wr_en), .acc_write_addr(wr_addr),
        .acc_write_data(wr_data),
        .acc_read_data(rdata3), .acc_read_data_valid(rvalid3),
        .acc_write_done(wdone3), .mem_addr(maddr3),
        .mem_rd_en(mrd3), .mem_wr_en(mwr3), .mem_wr_data(mwdata3),
        .mem_rd_data(mrdata3), .busy(busy3)
    );

    task automatic clr_inputs();
        rd_en = '0; wr_en = '0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rvalid, wdone, maddr, mrd, mwr, mwdata, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rvalid, wdone, maddr, mrd, mwr, mwdata, busy});
        end
        vectors++;
        if (rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        rd_addr[15:0] = 16'h1000;
        rd_en[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if (mrd !== 1'b1 || maddr !== 16'h1000 || mwr !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_issue: rd_en=%b addr=%h wr_en=%b want 1/1000/0",
                     mrd, maddr, mwr);
        end
        @(negedge clk);
        vectors++;
        if (rvalid !== 4'b0000 || mrd !== 1'b0 || maddr !== 16'h0) begin
            miscompares++;
            $display("FAIL rd_wait: valid=%b rd_en=%b addr=%h want 0/0/0",
                     rvalid, mrd, maddr);
        end
        @(negedge clk);
        vectors++;
        if (rvalid !== 4'b0001 || rdata !== pat(16'h1000)) begin
            miscompares++;
            $display("FAIL rd_resp: valid=%b data=%h want 0001 %h",
                     rvalid, rdata, pat(16'h1000));
        end
        rd_en[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_idle: busy=%b valid=%b want 0/0000", busy, rvalid);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge clk);
        wr_addr[47:32] = 16'h5000;
        wr_data[95:64] = 32'h5;
        wr_en[2] = 1'b1;
        @(negedge clk);
        vectors++;
        if (mwr !== 1'b1 || maddr !== 16'h5000 || mwdata !== 32'h5 ||
            mrd !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_issue: wr_en=%b addr=%h data=%h want 1/5000/5",
                     mwr, maddr, mwdata);
        end
        @(negedge clk);
        vectors++;
        if (wdone !== 4'b0100 || rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL wr_done: done=%b valid=%b want 0100/0000",
                     wdone, rvalid);
        end
        wr_en[2] = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || wdone !== 4'b0000 || mwdata !== 32'h0) begin
            miscompares++;
            $display("FAIL wr_idle: busy=%b done=%b data=%h want 0/0000/0",
                     busy, wdone, mwdata);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n = 0;
        int last = -1;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_addr[i*16 +: 16] = 16'h5000 + 16'(i);
            wr_data[i*32 +: 32] = 32'h100 + 32'(i);
        end
        wr_en = 4'b1111;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            if (mwr) begin
                vectors++;
                if (maddr !== 16'h5000 + 16'(exp_order[n]) ||
                    mwdata !== 32'h100 + 32'(exp_order[n])) begin
                    miscompares++;
                    $display("FAIL rr_issue%0d: addr=%h data=%h want req %0d",
                             n, maddr, mwdata, exp_order[n]);
                end
            end
            if (wdone !== 4'b0000) begin
                vectors++;
                if (wdone !== 4'(1 << exp_order[n]) ||
                    (last >= 0 && cyc - last != 3)) begin
                    miscompares++;
                    $display("FAIL rr_done%0d: done=%b gap=%0d want %b gap 3",
                             n, wdone, cyc - last, 4'(1 << exp_order[n]));
                end
                last = cyc;
                if (exp_order[n] != 0 || n == 4) wr_en[exp_order[n]] = 1'b0;
                n++;
            end
        end
        vectors++;
        if (n != 5) begin
            miscompares++;
            $display("FAIL rr_timeout: got %0d pulses want 5", n);
        end
        wr_en = '0;
    endtask

    task automatic test_read_write_same();
        int          exp_idx[4] = '{1, 2, 3, 1};
        bit          exp_rd[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] exp_a[4]   = '{16'h1040, 16'h5002, 16'h5003, 16'h5008};
        logic [31:0] exp_d[4]   = '{32'h0, 32'h2, 32'h3, 32'h1};
        int n = 0;
        do_reset();
        @(negedge clk);
        rd_addr[31:16] = 16'h1040;
        wr_addr[31:16] = 16'h5008;
        wr_addr[47:32] = 16'h5002;
        wr_addr[63:48] = 16'h5003;
        wr_data[63:32] = 32'h1;
        wr_data[95:64] = 32'h2;
        wr_data[127:96] = 32'h3;
        rd_en[1] = 1'b1;
        wr_en = 4'b1110;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            @(negedge clk);
            if (mrd || mwr) begin
                vectors++;
                if (mrd !== exp_rd[n] || maddr !== exp_a[n] ||
                    mwdata !== exp_d[n]) begin
                    miscompares++;
                    $display("FAIL rw_issue%0d: rd=%b addr=%h data=%h want %b %h %h",
                             n, mrd, maddr, mwdata, exp_rd[n], exp_a[n], exp_d[n]);
                end
            end
            if (rvalid !== 4'b0000 || wdone !== 4'b0000) begin
                vectors++;
                if (rvalid !== (exp_rd[n] ? 4'(1 << exp_idx[n]) : 4'b0) ||
                    wdone !== (exp_rd[n] ? 4'b0 : 4'(1 << exp_idx[n]))) begin
                    miscompares++;
                    $display("FAIL rw_pulse%0d: valid=%b done=%b want req %0d rd=%b",
                             n, rvalid, wdone, exp_idx[n], exp_rd[n]);
                end
                if (exp_rd[n]) rd_en[exp_idx[n]] = 1'b0;
                else wr_en[exp_idx[n]] = 1'b0;
                n++;
            end
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL rw_timeout: got %0d pulses want 4", n);
        end
        clr_inputs();
    endtask

    task automatic test_reset_in_rd_wait();
        int got = 0;
        int stray = 0;
        do_reset();
        @(negedge clk);
        rd_addr[15:0] = 16'h2000;
        rd_en[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rvalid, wdone, maddr, mrd, mwr, mwdata, busy} !== '0 ||
            rdata !== '0) begin
            miscompares++;
            $display("FAIL rst_mid: outs=%h rdata=%h want 0",
                     {rvalid, wdone, maddr, mrd, mwr, mwdata, busy}, rdata);
        end
        clr_inputs();
        wr_addr[15:0] = 16'h7000;
        wr_addr[31:16] = 16'h7001;
        wr_en = 4'b0011;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
            @(negedge clk);
            if (rvalid !== 4'b0000) stray++;
            if (wdone !== 4'b0000) begin
                got = 1;
                vectors++;
                if (wdone !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL rst_first: done=%b want 0001", wdone);
                end
            end
        end
        vectors++;
        if (got == 0 || stray != 0 || rdata !== '0) begin
            miscompares++;
            $display("FAIL rst_after: got=%0d stray=%0d rdata=%h want 1/0/0",
                     got, stray, rdata);
        end
        clr_inputs();
    endtask

    task automatic test_latency3();
        int got = 0;
        do_reset();
        @(negedge clk);
        rd_addr[63:48] = 16'h3000;
        rd_en[3] = 1'b1;
        @(negedge clk);
        vectors++;
        if (mrd3 !== 1'b1 || maddr3 !== 16'h3000) begin
            miscompares++;
            $display("FAIL l3_issue: rd_en=%b addr=%h want 1/3000", mrd3, maddr3);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (rvalid3 !== 4'b0000) begin
            miscompares++;
            $display("FAIL l3_early: valid=%b want 0000", rvalid3);
        end
        @(negedge clk);
        vectors++;
        if (rvalid3 !== 4'b1000 || rdata3 !== pat(16'h3000)) begin
            miscompares++;
            $display("FAIL l3_resp: valid=%b data=%h want 1000 %h",
                     rvalid3, rdata3, pat(16'h3000));
        end
        rd_en[3] = 1'b0;
        wr_addr[63:48] = 16'h6000;
        wr_data[127:96] = 32'h77;
        wr_en[3] = 1'b1;
        for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
            @(negedge clk);
            if (wdone3 !== 4'b0000) got = 1;
        end
        vectors++;
        if (got == 0 || wdone3 !== 4'b1000 || rdata3 !== pat(16'h3000)) begin
            miscompares++;
            $display("FAIL l3_hold: got=%0d done=%b data=%h want 1 1000 %h",
                     got, wdone3, rdata3, pat(16'h3000));
        end
        clr_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        clr_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_read_write_same();
        test_reset_in_rd_wait();
        test_latency3();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
